alu_rs: RTL and testbench
=========================

ALU_RS -- requirements
Module: alu_rs

Interface
REQ-001 The parameter RS_SIZE SHALL default to 8 and set the number of entries (power of two, 2..16).
REQ-002 The parameter TYPE_WIDTH SHALL default to 6 and set the width of the operation-type field consumed by the ALU.
REQ-003 The module SHALL have one clock and an asynchronous, active-low reset: clk_in input 1 (clock, all state on rising edge) and rst_in input 1 (asynchronous active-low reset).
REQ-004 The module SHALL have the following global ports: rdy_in input 1 (global enable; low freezes all state); flush input 1 (mispredict squash, effective only when rdy_in high).
REQ-005 The module SHALL have the following issue ports: issue_valid input 1; issue_rob_id input 32; issue_type input TYPE_WIDTH; issue_imm input 32; issue_qj_busy input 1; issue_qj input 32; issue_vj input 32; issue_qk_busy input 1; issue_qk input 32; issue_vk input 32.
REQ-006 The module SHALL have the port full output 1, high when no entry is free.
REQ-007 The module SHALL have the following CDB snoop ports: cdb0_valid input 1; cdb0_rob_id input 32; cdb0_value input 32; cdb1_valid input 1; cdb1_rob_id input 32; cdb1_value input 32.
REQ-008 The module SHALL have the following ALU-side output ports: alu_en output 1; alu_rob_id output 32; alu_data_j output 32; alu_data_k output 32; alu_imm output 32; alu_type output TYPE_WIDTH, all registered.

Function
REQ-009 Each entry SHALL hold: busy, rob_id, type, imm, qj_busy, qj, vj, qk_busy, qk, vk.
REQ-010 full SHALL be combinational from the current busy vector: high iff all RS_SIZE entries are busy.
REQ-011 On a rising edge with rdy_in high, flush low, issue_valid high and full low, the lowest-index non-busy entry SHALL be written and marked busy.
REQ-012 issue_valid while full is high SHALL be ignored, with no entry modified.
REQ-013 Issue-time forwarding: if issue_qj_busy and a cdbN_valid with cdbN_rob_id == issue_qj occur in the same cycle, the entry SHALL store qj_busy=0 and vj=cdbN_value; the same rule SHALL apply for k.
REQ-014 Wakeup: every busy entry with qj_busy (qk_busy) set whose tag matches a valid CDB SHALL clear the flag and latch the value on that edge.
REQ-015 If both CDBs match the same tag, cdb0 SHALL take priority.
REQ-016 An entry SHALL be ready when busy && !qj_busy && !qk_busy, evaluated on pre-edge state.
REQ-017 Each edge with rdy_in high and flush low, the lowest-index ready entry SHALL be selected, its fields copied to the alu_* outputs, alu_en set to 1, and the entry cleared (busy=0).
REQ-018 If no entry is ready on such an edge, alu_en SHALL be set to 0, with the other alu_* outputs don't-care (implementation holds them).
REQ-019 Latency: an operand-ready instruction issued at edge N SHALL reach alu_en=1 at edge N+1 at the earliest; an entry woken by CDB at edge N SHALL dispatch at edge N+1 at the earliest.
REQ-020 An entry freed by dispatch at edge N SHALL not be writable by issue at edge N; it SHALL be writable from edge N+1.
REQ-021 Wakeup, issue and dispatch on distinct entries at the same edge SHALL all take effect.
REQ-022 With rdy_in low, entries and all outputs SHALL hold, and CDB and issue inputs SHALL be ignored.
REQ-023 Flush with rdy_in high SHALL clear all busy bits and alu_en at that edge and ignore issue in the same cycle.
REQ-024 Tag comparison SHALL be a full 32-bit equality check.

Reset
REQ-025 While rst_in is low, all entry busy/qj_busy/qk_busy bits SHALL be 0, alu_en SHALL be 0, and alu_rob_id, alu_data_j, alu_data_k, alu_imm and alu_type SHALL be 0, independent of the clock.
REQ-026 Reset asserted mid-operation SHALL discard all pending entries immediately.
REQ-027 The first active edge after rst_in deasserts SHALL behave as normal operation on an empty station.

Verification
REQ-028 The bench SHALL cover: issue rob 5, add, vj=3, vk=4, no deps at edge 1 -> edge 2: alu_en=1, alu_rob_id=5, alu_data_j=3, alu_data_k=4.
REQ-029 The bench SHALL cover: issue rob 7 with qj=2 busy; cdb1 broadcasts rob 2 value 0x10 two cycles later -> dispatch one edge after the broadcast with alu_data_j=0x10.
REQ-030 The bench SHALL cover: issue with qk=9 in the same cycle cdb0 broadcasts rob 9 value 0xAA -> dispatch next edge with alu_data_k=0xAA.
REQ-031 The bench SHALL cover: 8 dependent issues -> full=1; a 9th issue is ignored; wakeup of entry 0 dispatches it, full drops, and the next issue lands in entry 0 one edge later.
REQ-032 The bench SHALL cover: 3 busy entries, flush with rdy_in=1 -> next cycle full=0, alu_en=0, and no later dispatch of the squashed rob_ids; repeating with rdy_in=0 -> no effect.
REQ-033 The bench SHALL cover: rst_in pulled low between clock edges while alu_en=1 -> alu_en=0 immediately and all entries empty.

Source files
------------

// File: rtl/alu_rs.sv
// ALU reservation station: tag-snooping operand capture, lowest-index issue
// allocation and lowest-index dispatch of ready entries to a registered ALU port.
module alu_rs #(
  parameter int RS_SIZE    = 8,
  parameter int TYPE_WIDTH = 6
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  flush,
  input  logic                  issue_valid,
  input  logic [31:0]           issue_rob_id,
  input  logic [TYPE_WIDTH-1:0] issue_type,
  input  logic [31:0]           issue_imm,
  input  logic                  issue_qj_busy,
  input  logic [31:0]           issue_qj,
  input  logic [31:0]           issue_vj,
  input  logic                  issue_qk_busy,
  input  logic [31:0]           issue_qk,
  input  logic [31:0]           issue_vk,
  output logic                  full,
  input  logic                  cdb0_valid,
  input  logic [31:0]           cdb0_rob_id,
  input  logic [31:0]           cdb0_value,
  input  logic                  cdb1_valid,
  input  logic [31:0]           cdb1_rob_id,
  input  logic [31:0]           cdb1_value,
  output logic                  alu_en,
  output logic [31:0]           alu_rob_id,
  output logic [31:0]           alu_data_j,
  output logic [31:0]           alu_data_k,
  output logic [31:0]           alu_imm,
  output logic [TYPE_WIDTH-1:0] alu_type
);
  localparam int IW = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  typedef struct packed {
    logic                  busy;
    logic [31:0]           rob_id;
    logic [TYPE_WIDTH-1:0] typ;
    logic [31:0]           imm;
    logic                  qj_busy;
    logic [31:0]           qj;
    logic [31:0]           vj;
    logic                  qk_busy;
    logic [31:0]           qk;
    logic [31:0]           vk;
  } rs_entry_t;

  rs_entry_t          ent_q [RS_SIZE];
  rs_entry_t          ent_d [RS_SIZE];
  logic [RS_SIZE-1:0] busy_vec, rdy_vec;
  logic [IW-1:0]      free_idx, disp_idx;
  logic               disp_ok;
  rs_entry_t          disp_e;

  // Returns {still_busy, value}; cdb0 wins when both buses carry the tag.
  function automatic logic [32:0] snoop(input logic busy, input logic [31:0] tag,
                                        input logic [31:0] val);
    if (busy && cdb0_valid && cdb0_rob_id == tag)      snoop = {1'b0, cdb0_value};
    else if (busy && cdb1_valid && cdb1_rob_id == tag) snoop = {1'b0, cdb1_value};
    else                                               snoop = {busy, val};
  endfunction

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      busy_vec[i] = ent_q[i].busy;
      rdy_vec[i]  = ent_q[i].busy && !ent_q[i].qj_busy && !ent_q[i].qk_busy;
    end
  end

  assign full = &busy_vec;

  // Downward scan leaves the lowest matching index in place.
  always_comb begin
    free_idx = '0;
    disp_idx = '0;
    disp_ok  = 1'b0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy_vec[i]) free_idx = IW'(i);
      if (rdy_vec[i]) begin
        disp_idx = IW'(i);
        disp_ok  = 1'b1;
      end
    end
  end

  assign disp_e = ent_q[disp_idx];

  // Slot picked from pre-edge busy bits, so a slot vacated by this edge's
  // dispatch only becomes allocatable on the following edge.
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      ent_d[i] = ent_q[i];
      if (ent_q[i].busy) begin
        {ent_d[i].qj_busy, ent_d[i].vj} = snoop(ent_q[i].qj_busy, ent_q[i].qj, ent_q[i].vj);
        {ent_d[i].qk_busy, ent_d[i].vk} = snoop(ent_q[i].qk_busy, ent_q[i].qk, ent_q[i].vk);
      end
      if (disp_ok && disp_idx == IW'(i)) ent_d[i].busy = 1'b0;
      if (issue_valid && !full && free_idx == IW'(i)) begin
        ent_d[i].busy   = 1'b1;
        ent_d[i].rob_id = issue_rob_id;
        ent_d[i].typ    = issue_type;
        ent_d[i].imm    = issue_imm;
        ent_d[i].qj     = issue_qj;
        ent_d[i].qk     = issue_qk;
        {ent_d[i].qj_busy, ent_d[i].vj} = snoop(issue_qj_busy, issue_qj, issue_vj);
        {ent_d[i].qk_busy, ent_d[i].vk} = snoop(issue_qk_busy, issue_qk, issue_vk);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < RS_SIZE; i++) ent_q[i] <= '0;
    end else if (rdy_in) begin
      for (int i = 0; i < RS_SIZE; i++) ent_q[i] <= flush ? '0 : ent_d[i];
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      alu_en     <= 1'b0;
      alu_rob_id <= '0;
      alu_data_j <= '0;
      alu_data_k <= '0;
      alu_imm    <= '0;
      alu_type   <= '0;
    end else if (rdy_in) begin
      alu_en <= disp_ok && !flush;
      if (disp_ok && !flush) begin
        alu_rob_id <= disp_e.rob_id;
        alu_data_j <= disp_e.vj;
        alu_data_k <= disp_e.vk;
        alu_imm    <= disp_e.imm;
        alu_type   <= disp_e.typ;
      end
    end
  end
endmodule

// File: tb/tb_alu_rs.sv
// Bench for alu_rs: directed vector table, hand-written corner sequences and a
// randomized run against a slot-array reference model.
module tb_alu_rs;
  localparam int N = 8;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, flush;
  logic        issue_valid, issue_qj_busy, issue_qk_busy;
  logic [31:0] issue_rob_id, issue_imm, issue_qj, issue_vj, issue_qk, issue_vk;
  logic [5:0]  issue_type;
  logic        full;
  logic        cdb0_valid, cdb1_valid;
  logic [31:0] cdb0_rob_id, cdb0_value, cdb1_rob_id, cdb1_value;
  logic        alu_en;
  logic [31:0] alu_rob_id, alu_data_j, alu_data_k, alu_imm;
  logic [5:0]  alu_type;

  int n_tests = 0;
  int n_fail  = 0;

  alu_rs #(.RS_SIZE(N), .TYPE_WIDTH(6)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
    .issue_valid(issue_valid), .issue_rob_id(issue_rob_id), .issue_type(issue_type),
    .issue_imm(issue_imm), .issue_qj_busy(issue_qj_busy), .issue_qj(issue_qj),
    .issue_vj(issue_vj), .issue_qk_busy(issue_qk_busy), .issue_qk(issue_qk),
    .issue_vk(issue_vk), .full(full),
    .cdb0_valid(cdb0_valid), .cdb0_rob_id(cdb0_rob_id), .cdb0_value(cdb0_value),
    .cdb1_valid(cdb1_valid), .cdb1_rob_id(cdb1_rob_id), .cdb1_value(cdb1_value),
    .alu_en(alu_en), .alu_rob_id(alu_rob_id), .alu_data_j(alu_data_j),
    .alu_data_k(alu_data_k), .alu_imm(alu_imm), .alu_type(alu_type)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    bit iv; logic [31:0] rob;
    bit qjb; logic [31:0] qj, vj;
    bit qkb; logic [31:0] qk, vk;
    bit c0v; logic [31:0] c0id, c0val;
    bit c1v; logic [31:0] c1id, c1val;
    bit e_en; logic [31:0] e_rob, e_j, e_k; bit e_full;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    rdy_in = 1'b1; flush = 1'b0;
    issue_valid = 1'b0; issue_rob_id = '0; issue_type = '0; issue_imm = '0;
    issue_qj_busy = 1'b0; issue_qj = '0; issue_vj = '0;
    issue_qk_busy = 1'b0; issue_qk = '0; issue_vk = '0;
    cdb0_valid = 1'b0; cdb0_rob_id = '0; cdb0_value = '0;
    cdb1_valid = 1'b0; cdb1_rob_id = '0; cdb1_value = '0;
  endtask

  // imm and type are derived from the rob id so they can be checked too
  task automatic iss(input logic [31:0] rob, input bit qjb, input logic [31:0] qj,
                     input logic [31:0] vj, input bit qkb, input logic [31:0] qk,
                     input logic [31:0] vk);
    issue_valid = 1'b1; issue_rob_id = rob; issue_type = rob[5:0]; issue_imm = rob << 4;
    issue_qj_busy = qjb; issue_qj = qj; issue_vj = vj;
    issue_qk_busy = qkb; issue_qk = qk; issue_vk = vk;
  endtask

  task automatic bcast0(input logic [31:0] id, input logic [31:0] val);
    cdb0_valid = 1'b1; cdb0_rob_id = id; cdb0_value = val;
  endtask

  task automatic expect_disp(input string tag, input logic [31:0] rob,
                             input logic [31:0] j, input logic [31:0] k);
    chk({tag, " en"}, {31'b0, alu_en}, 32'd1);
    chk({tag, " rob"}, alu_rob_id, rob);
    chk({tag, " j"}, alu_data_j, j);
    chk({tag, " k"}, alu_data_k, k);
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    idle();
    if (v.iv) iss(v.rob, v.qjb, v.qj, v.vj, v.qkb, v.qk, v.vk);
    cdb0_valid = v.c0v; cdb0_rob_id = v.c0id; cdb0_value = v.c0val;
    cdb1_valid = v.c1v; cdb1_rob_id = v.c1id; cdb1_value = v.c1val;
    step();
    chk($sformatf("vec%0d en", idx), {31'b0, alu_en}, {31'b0, v.e_en});
    chk($sformatf("vec%0d full", idx), {31'b0, full}, {31'b0, v.e_full});
    if (v.e_en) begin
      chk($sformatf("vec%0d rob", idx), alu_rob_id, v.e_rob);
      chk($sformatf("vec%0d j", idx), alu_data_j, v.e_j);
      chk($sformatf("vec%0d k", idx), alu_data_k, v.e_k);
      chk($sformatf("vec%0d imm", idx), alu_imm, v.e_rob << 4);
      chk($sformatf("vec%0d type", idx), {26'b0, alu_type}, {26'b0, v.e_rob[5:0]});
    end
  endtask

  // Reference model: a slot array plus the last value presented to the ALU.
  bit          m_b [N], m_qjb [N], m_qkb [N];
  logic [31:0] m_rob [N], m_qj [N], m_vj [N], m_qk [N], m_vk [N];
  bit          m_en;
  logic [31:0] m_arob, m_aj, m_ak;

  function automatic bit on_cdb(input logic [31:0] tag, output logic [31:0] val);
    val = '0;
    if (cdb0_valid && cdb0_rob_id == tag) begin val = cdb0_value; return 1'b1; end
    if (cdb1_valid && cdb1_rob_id == tag) begin val = cdb1_value; return 1'b1; end
    return 1'b0;
  endfunction

  task automatic model_edge();
    int d, f;
    logic [31:0] v;
    if (!rdy_in) return;
    if (flush) begin
      for (int i = 0; i < N; i++) m_b[i] = 0;
      m_en = 0;
      return;
    end
    d = -1; f = -1;
    for (int i = 0; i < N; i++) if (m_b[i] && !m_qjb[i] && !m_qkb[i]) begin d = i; break; end
    for (int i = 0; i < N; i++) if (!m_b[i]) begin f = i; break; end
    m_en = (d >= 0);
    if (d >= 0) begin
      m_arob = m_rob[d]; m_aj = m_vj[d]; m_ak = m_vk[d]; m_b[d] = 0;
    end
    for (int i = 0; i < N; i++) if (m_b[i]) begin
      if (m_qjb[i] && on_cdb(m_qj[i], v)) begin m_qjb[i] = 0; m_vj[i] = v; end
      if (m_qkb[i] && on_cdb(m_qk[i], v)) begin m_qkb[i] = 0; m_vk[i] = v; end
    end
    if (issue_valid && f >= 0) begin
      m_b[f] = 1; m_rob[f] = issue_rob_id;
      m_qj[f] = issue_qj; m_vj[f] = issue_vj; m_qjb[f] = issue_qj_busy;
      m_qk[f] = issue_qk; m_vk[f] = issue_vk; m_qkb[f] = issue_qk_busy;
      if (m_qjb[f] && on_cdb(issue_qj, v)) begin m_qjb[f] = 0; m_vj[f] = v; end
      if (m_qkb[f] && on_cdb(issue_qk, v)) begin m_qkb[f] = 0; m_vk[f] = v; end
    end
  endtask

  function automatic bit model_full();
    for (int i = 0; i < N; i++) if (!m_b[i]) return 1'b0;
    return 1'b1;
  endfunction

  vec_t tbl[$];

  initial begin
    // {iv,rob,qjb,qj,vj,qkb,qk,vk, c0v,c0id,c0val, c1v,c1id,c1val, e_en,e_rob,e_j,e_k,e_full}
    tbl.push_back('{1, 5, 0,0,3, 0,0,4,        0,0,0, 0,0,0,       0,0,0,0,0});
    tbl.push_back('{0, 0, 0,0,0, 0,0,0,        0,0,0, 0,0,0,       1,5,3,4,0});
    tbl.push_back('{1, 7, 1,2,0, 0,0,32'h22,   0,0,0, 0,0,0,       0,0,0,0,0});
    tbl.push_back('{0, 0, 0,0,0, 0,0,0,        0,0,0, 0,0,0,       0,0,0,0,0});
    tbl.push_back('{0, 0, 0,0,0, 0,0,0,        0,0,0, 1,2,32'h10,  0,0,0,0,0});
    tbl.push_back('{0, 0, 0,0,0, 0,0,0,        0,0,0, 0,0,0,       1,7,32'h10,32'h22,0});
    tbl.push_back('{1, 11, 0,0,1, 1,9,0,       1,9,32'hAA, 0,0,0,  0,0,0,0,0});
    tbl.push_back('{0, 0, 0,0,0, 0,0,0,        0,0,0, 0,0,0,       1,11,1,32'hAA,0});
    tbl.push_back('{1, 12, 1,3,0, 0,0,5,       0,0,0, 0,0,0,       0,0,0,0,0});
    tbl.push_back('{0, 0, 0,0,0, 0,0,0,        1,3,32'h33, 1,3,32'h44, 0,0,0,0,0});
    tbl.push_back('{0, 0, 0,0,0, 0,0,0,        0,0,0, 0,0,0,       1,12,32'h33,5,0});
    tbl.push_back('{1, 13, 1,32'h10000003,0, 0,0,6, 0,0,0, 0,0,0,  0,0,0,0,0});
    tbl.push_back('{0, 0, 0,0,0, 0,0,0,        1,3,32'h55, 0,0,0,  0,0,0,0,0});
    tbl.push_back('{0, 0, 0,0,0, 0,0,0,        0,0,0, 0,0,0,       0,0,0,0,0});
    tbl.push_back('{0, 0, 0,0,0, 0,0,0,        1,32'h10000003,32'h66, 0,0,0, 0,0,0,0,0});
    tbl.push_back('{0, 0, 0,0,0, 0,0,0,        0,0,0, 0,0,0,       1,13,32'h66,6,0});

    idle();
    rst_in = 1'b0;
    #3;
    chk("reset en", {31'b0, alu_en}, 32'd0);
    chk("reset rob", alu_rob_id, 32'd0);
    chk("reset data_j", alu_data_j, 32'd0);
    chk("reset full", {31'b0, full}, 32'd0);
    step();
    rst_in = 1'b1;

    foreach (tbl[i]) apply_vec(tbl[i], i);

    // fill with eight dependent entries, then a ninth issue must be dropped
    for (int i = 0; i < N; i++) begin
      idle(); iss(20 + i, 1, 200 + i, 0, 0, 0, i); step();
      chk($sformatf("fill%0d full", i), {31'b0, full}, {31'b0, i == N - 1});
    end
    idle(); iss(99, 0, 0, 1, 0, 0, 2); step();
    chk("full drop9 full", {31'b0, full}, 32'd1);
    chk("full drop9 en", {31'b0, alu_en}, 32'd0);
    idle(); bcast0(200, 32'hE0); step();
    chk("full wake en", {31'b0, alu_en}, 32'd0);
    chk("full wake full", {31'b0, full}, 32'd1);
    idle(); iss(30, 0, 0, 1, 0, 0, 1); step();
    expect_disp("full disp", 20, 32'hE0, 0);
    chk("full disp full", {31'b0, full}, 32'd0);
    idle(); iss(31, 0, 0, 7, 0, 0, 8); step();
    chk("refill full", {31'b0, full}, 32'd1);
    chk("refill en", {31'b0, alu_en}, 32'd0);
    idle(); step();
    expect_disp("refill disp", 31, 7, 8);
    chk("refill disp full", {31'b0, full}, 32'd0);
    idle(); flush = 1'b1; step();

    // flush squashes pending entries
    for (int i = 0; i < 3; i++) begin idle(); iss(40 + i, 1, 300 + i, 0, 0, 0, 0); step(); end
    idle(); flush = 1'b1; step();
    chk("flush full", {31'b0, full}, 32'd0);
    chk("flush en", {31'b0, alu_en}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      idle(); if (i < 3) bcast0(300 + i, 32'h77); step();
      chk($sformatf("flush post%0d en", i), {31'b0, alu_en}, 32'd0);
    end
    // flush (and CDB) with rdy_in low must be ignored
    for (int i = 0; i < 3; i++) begin idle(); iss(50 + i, 1, 400 + i, 0, 0, 0, i); step(); end
    idle(); rdy_in = 1'b0; flush = 1'b1; bcast0(400, 32'h40); step();
    chk("noflush full", {31'b0, full}, 32'd0);
    chk("noflush en", {31'b0, alu_en}, 32'd0);
    idle(); bcast0(400, 32'h40); step();
    chk("noflush wake en", {31'b0, alu_en}, 32'd0);
    idle(); bcast0(401, 32'h41); step(); expect_disp("noflush d50", 50, 32'h40, 0);
    idle(); bcast0(402, 32'h42); step(); expect_disp("noflush d51", 51, 32'h41, 1);
    idle(); step(); expect_disp("noflush d52", 52, 32'h42, 2);
    idle(); step(); chk("noflush end en", {31'b0, alu_en}, 32'd0);

    // rdy_in low holds outputs and ignores inputs; then async reset mid-operation
    idle(); iss(60, 0, 0, 6, 0, 0, 6); step();
    idle(); iss(61, 1, 500, 0, 0, 0, 1); step(); expect_disp("hold pre", 60, 6, 6);
    idle(); rdy_in = 1'b0; bcast0(500, 32'h50); iss(62, 0, 0, 2, 0, 0, 2); step();
    expect_disp("hold", 60, 6, 6);
    idle(); step(); chk("hold after en", {31'b0, alu_en}, 32'd0);
    idle(); bcast0(500, 32'h50); iss(63, 1, 600, 0, 0, 0, 3); step();
    chk("pre rst wake en", {31'b0, alu_en}, 32'd0);
    idle(); step(); expect_disp("pre rst", 61, 32'h50, 1);
    #2 rst_in = 1'b0;
    #1;
    chk("async rst en", {31'b0, alu_en}, 32'd0);
    chk("async rst rob", alu_rob_id, 32'd0);
    chk("async rst k", alu_data_k, 32'd0);
    chk("async rst full", {31'b0, full}, 32'd0);
    #2 rst_in = 1'b1;
    idle(); bcast0(600, 32'h60); step();
    chk("post rst en0", {31'b0, alu_en}, 32'd0);
    idle(); step();
    chk("post rst en1", {31'b0, alu_en}, 32'd0);

    // randomized run from an empty station
    for (int i = 0; i < N; i++) m_b[i] = 0;
    m_en = 0;
    for (int c = 0; c < 400; c++) begin
      idle();
      rdy_in = ($urandom_range(0, 7) != 0);
      flush  = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 1) == 1)
        iss($urandom, $urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom,
            $urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom);
      if ($urandom_range(0, 2) == 0) bcast0($urandom_range(0, 7), $urandom);
      if ($urandom_range(0, 2) == 0) begin
        cdb1_valid = 1'b1; cdb1_rob_id = $urandom_range(0, 7); cdb1_value = $urandom;
      end
      #1;
      chk($sformatf("rnd%0d full", c), {31'b0, full}, {31'b0, model_full()});
      model_edge();
      step();
      chk($sformatf("rnd%0d en", c), {31'b0, alu_en}, {31'b0, m_en});
      if (m_en) begin
        chk($sformatf("rnd%0d rob", c), alu_rob_id, m_arob);
        chk($sformatf("rnd%0d j", c), alu_data_j, m_aj);
        chk($sformatf("rnd%0d k", c), alu_data_k, m_ak);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
